// File: rtl/ldtu_out_pkg.sv
// ---------------------------------------------------------------------------
// ldtu_out_pkg
// Shared definitions for the LDTU output stage: FSM state encoding and the
// fixed idle / sync patterns driven onto the output lanes. The patterns are
// 32 bits wide here; users resize them to NBITS with a size cast.
// ---------------------------------------------------------------------------
package ldtu_out_pkg;

   typedef enum logic [1:0] {
      RUN  = 2'd0,
      SYNC = 2'd1,
      TEST = 2'd2
   } ldtu_state_e;

   localparam logic [31:0] IDLE_WORD = 32'hEAAA_AAAA;
   localparam logic [31:0] SYNC_WORD = 32'h5A5A_5A5A;

endpackage

// File: rtl/ldtu_sync_fifo.sv
// ---------------------------------------------------------------------------
// ldtu_sync_fifo
// Single-clock FIFO with first-word-fall-through read data. Pointers carry
// one extra MSB so that full and empty can be told apart.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   clr_i               synchronous clear of both pointers (push/pop ignored)
//   push_i, data_i      write request and data
//   pop_i               read request; data_o is the current head word
//   full_o, empty_o     occupancy flags
//   level_o             number of stored words (0..DEPTH)
// ---------------------------------------------------------------------------
module ldtu_sync_fifo #(
   parameter int NBITS = 32,
   parameter int DEPTH = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     clr_i,
   input  logic                     push_i,
   input  logic [NBITS-1:0]         data_i,
   input  logic                     pop_i,
   output logic [NBITS-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, wr_d;
   logic [AW:0]      rd_q, rd_d;
   logic [NBITS-1:0] mem_q [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign level_o = wr_q - rd_q;
   assign data_o  = mem_q[rd_q[AW-1:0]];

   // A push into a full FIFO still goes through when the head leaves in the
   // same cycle, since the slot being written is freed at the same edge.
   assign pop_ok  = pop_i & ~empty_o & ~clr_i;
   assign push_ok = push_i & (~full_o | pop_ok) & ~clr_i;

   always_comb begin
      wr_d = wr_q;
      rd_d = rd_q;
      if (clr_i) begin
         wr_d = '0;
         rd_d = '0;
      end else begin
         if (push_ok) wr_d = wr_q + 1'b1;
         if (pop_ok)  rd_d = rd_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end

   // Storage needs no reset: a word is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/ldtu_out_stage.sv
// ---------------------------------------------------------------------------
// ldtu_out_stage
// Output stage of the LDTU: words from the control unit are queued in a FIFO
// and distributed round-robin over NLANES registered output lanes. A rising
// handshake replaces the lanes with a sync pattern for HS_CYCLES cycles, and
// test_mode passes the ATU test patterns straight to the lanes.
// Ports:
//   CLK, RST_N      clock, asynchronous active-low reset
//   write_signal    push data_in into the FIFO this cycle
//   data_in         encoded word (NBITS)
//   test_mode       level, selects ATU patterns (TEST state)
//   data_atu        ATU patterns, lane i at [i*NBITS +: NBITS]
//   handshake       level, rising edge requests a sync burst
//   data_out        registered lanes, same packing as data_atu
//   full            FIFO holds DEPTH words
//   losing_data     one-cycle pulse after a dropped write
//   fifo_level      FIFO occupancy
//   lost_count      dropped-write counter, saturates at 255
// ---------------------------------------------------------------------------
module ldtu_out_stage
   import ldtu_out_pkg::*;
#(
   parameter int NBITS     = 32,
   parameter int NLANES    = 4,
   parameter int DEPTH     = 16,
   parameter int HS_CYCLES = 8
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic                      write_signal,
   input  logic [NBITS-1:0]          data_in,
   input  logic                      test_mode,
   input  logic [NLANES*NBITS-1:0]   data_atu,
   input  logic                      handshake,
   output logic [NLANES*NBITS-1:0]   data_out,
   output logic                      full,
   output logic                      losing_data,
   output logic [$clog2(DEPTH):0]    fifo_level,
   output logic [7:0]                lost_count
);

   localparam int LW = (NLANES > 1) ? $clog2(NLANES) : 1;
   localparam int CW = (HS_CYCLES > 1) ? $clog2(HS_CYCLES) : 1;

   localparam logic [NBITS-1:0] IDLE_W = NBITS'(IDLE_WORD);
   localparam logic [NBITS-1:0] SYNC_W = NBITS'(SYNC_WORD);

   typedef logic [NLANES-1:0][NBITS-1:0] lanes_t;

   ldtu_state_e   state_q, state_d;
   logic [LW-1:0] lane_q, lane_d;
   logic [CW-1:0] cnt_q, cnt_d;
   lanes_t        dout_q, dout_d;
   lanes_t        atu;
   logic          hs_q;
   logic          hs_rise;
   logic          losing_q;
   logic [7:0]    lost_q;

   logic             fifo_push;
   logic             fifo_pop;
   logic             fifo_clr;
   logic             fifo_full;
   logic             fifo_empty;
   logic [NBITS-1:0] fifo_rdata;
   logic             drop;

   assign atu     = data_atu;
   assign hs_rise = handshake & ~hs_q;

   // TEST keeps the FIFO flushed; pushes there are ignored outright and do
   // not count as drops.
   assign fifo_clr  = (state_q == TEST);
   assign fifo_push = write_signal & ~fifo_clr;
   assign fifo_pop  = (state_q == RUN) & ~fifo_empty;
   assign drop      = fifo_push & fifo_full & ~fifo_pop;

   ldtu_sync_fifo #(
      .NBITS (NBITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .clr_i   (fifo_clr),
      .push_i  (fifo_push),
      .data_i  (data_in),
      .pop_i   (fifo_pop),
      .data_o  (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   always_comb begin
      state_d = state_q;
      lane_d  = lane_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      unique case (state_q)
         RUN: begin
            dout_d[lane_q] = fifo_pop ? fifo_rdata : IDLE_W;
            lane_d = (lane_q == LW'(NLANES - 1)) ? '0 : lane_q + 1'b1;
            if (hs_rise) begin
               state_d = SYNC;
               cnt_d   = CW'(HS_CYCLES - 1);
            end
         end
         SYNC: begin
            // cnt_q counts down the remaining sync cycles; a new handshake
            // edge reloads it so the burst restarts from full length.
            dout_d = {NLANES{SYNC_W}};
            lane_d = '0;
            if (hs_rise)
               cnt_d = CW'(HS_CYCLES - 1);
            else if (cnt_q == '0)
               state_d = RUN;
            else
               cnt_d = cnt_q - 1'b1;
         end
         TEST: begin
            dout_d  = atu;
            lane_d  = '0;
            state_d = RUN;
         end
         default: begin
            state_d = RUN;
            lane_d  = '0;
         end
      endcase
      // test_mode overrides everything, including a pending handshake.
      if (test_mode) state_d = TEST;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= RUN;
         lane_q   <= '0;
         cnt_q    <= '0;
         dout_q   <= {NLANES{IDLE_W}};
         hs_q     <= 1'b0;
         losing_q <= 1'b0;
         lost_q   <= '0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         cnt_q    <= cnt_d;
         dout_q   <= dout_d;
         hs_q     <= handshake;
         losing_q <= drop;
         if (drop && (lost_q != 8'hFF)) lost_q <= lost_q + 8'd1;
      end
   end

   assign data_out    = dout_q;
   assign full        = fifo_full;
   assign losing_data = losing_q;
   assign lost_count  = lost_q;

endmodule

// File: tb/tb_ldtu_out_stage.sv
module tb_ldtu_out_stage;

   localparam logic [31:0] IDLE  = 32'hEAAA_AAAA;
   localparam logic [31:0] SYNCW = 32'h5A5A_5A5A;

   localparam int K_LANE  = 0;
   localparam int K_FULL  = 1;
   localparam int K_LOSE  = 2;
   localparam int K_LEVEL = 3;
   localparam int K_LOST  = 4;

   logic         CLK = 1'b0;
   logic         RST_N = 1'b0;
   logic         write_signal = 1'b0;
   logic [31:0]  data_in = '0;
   logic         test_mode = 1'b0;
   logic [127:0] data_atu = '0;
   logic         handshake = 1'b0;
   logic [127:0] data_out;
   logic         full;
   logic         losing_data;
   logic [4:0]   fifo_level;
   logic [7:0]   lost_count;

   ldtu_out_stage #(
      .NBITS(32), .NLANES(4), .DEPTH(16), .HS_CYCLES(8)
   ) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .write_signal (write_signal),
      .data_in      (data_in),
      .test_mode    (test_mode),
      .data_atu     (data_atu),
      .handshake    (handshake),
      .data_out     (data_out),
      .full         (full),
      .losing_data  (losing_data),
      .fifo_level   (fifo_level),
      .lost_count   (lost_count)
   );

   always #5 CLK = ~CLK;

   // cyc = number of rising edges seen so far
   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          kind;
      int          lane;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Keep the scoreboard ordered by observation cycle.
   function automatic void expect_at(int c, int kind, int lane, logic [31:0] v, string nm);
      exp_t e;
      int   pos;
      e.cyc = c; e.kind = kind; e.lane = lane; e.val = v; e.name = nm;
      pos = sb.size();
      for (int i = 0; i < sb.size(); i++) begin
         if (sb[i].cyc > c) begin
            pos = i;
            break;
         end
      end
      sb.insert(pos, e);
   endfunction

   function automatic void expect_lanes(int c, logic [31:0] v, string nm);
      for (int l = 0; l < 4; l++) expect_at(c, K_LANE, l, v, $sformatf("%s_l%0d", nm, l));
   endfunction

   // Monitor: every falling edge, compare whatever is due this cycle.
   always @(negedge CLK) begin : mon
      exp_t        e;
      logic [31:0] act;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         case (e.kind)
            K_LANE:  act = data_out[e.lane*32 +: 32];
            K_FULL:  act = {31'b0, full};
            K_LOSE:  act = {31'b0, losing_data};
            K_LEVEL: act = 32'(fifo_level);
            K_LOST:  act = 32'(lost_count);
            default: act = 'x;
         endcase
         checks++;
         if (e.cyc != cyc) begin
            errors++;
            $display("FAIL %s: due at cycle %0d, reached at %0d", e.name, e.cyc, cyc);
         end else if (act !== e.val) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h, required %h", e.name, cyc, act, e.val);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : stim
      int s;
      int r;

      // ---------------- reset state ----------------
      tick(); tick();
      expect_lanes(cyc, IDLE, "rst");
      expect_at(cyc, K_FULL,  0, 0, "rst_full");
      expect_at(cyc, K_LOSE,  0, 0, "rst_losing");
      expect_at(cyc, K_LEVEL, 0, 0, "rst_level");
      expect_at(cyc, K_LOST,  0, 0, "rst_lost");
      tick();
      RST_N = 1'b1;
      r = cyc;

      // ---------------- basic run: 5 words ----------------
      // Lane pointer is 0 again after 4 edges, so push 0x11 at edge r+4.
      tick(); tick(); tick();
      expect_at(r+4, K_LANE, 0, IDLE,     "run_l0_before");
      expect_at(r+5, K_LANE, 0, 32'h11,   "run_l0_11");
      expect_at(r+5, K_LEVEL, 0, 1,       "run_level");
      expect_at(r+6, K_LANE, 1, 32'h22,   "run_l1_22");
      expect_at(r+7, K_LANE, 2, 32'h33,   "run_l2_33");
      expect_at(r+8, K_LANE, 3, 32'h44,   "run_l3_44");
      expect_at(r+9, K_LANE, 0, 32'h55,   "run_l0_55");
      expect_at(r+9, K_LANE, 1, 32'h22,   "run_l1_hold");
      expect_at(r+10, K_LANE, 1, IDLE,    "run_l1_idle");
      expect_at(r+10, K_LEVEL, 0, 0,      "run_level_empty");
      expect_at(r+11, K_LANE, 2, IDLE,    "run_l2_idle");
      for (int i = 0; i < 5; i++) begin
         data_in = 32'h11 * (i + 1);
         write_signal = 1'b1;
         tick();
      end
      write_signal = 1'b0;
      repeat (6) tick();

      // ---------------- single handshake ----------------
      s = cyc;
      expect_at(s+1, K_LANE, 0, IDLE, "hs_pre");
      for (int c = 2; c <= 9; c++) expect_at(s+c, K_LANE, 0, SYNCW, $sformatf("hs_sync%0d", c-1));
      expect_at(s+9, K_LANE, 3, SYNCW, "hs_l3_sync");
      expect_at(s+10, K_LANE, 0, 32'h77, "hs_resume_l0");
      handshake = 1'b1;
      tick();
      handshake = 1'b0;
      tick();
      data_in = 32'h77;
      write_signal = 1'b1;
      tick();
      write_signal = 1'b0;
      repeat (10) tick();

      // ---------------- overflow and saturation ----------------
      s = cyc;
      expect_at(s+16, K_FULL,  0, 0,     "ovf_notfull");
      expect_at(s+17, K_FULL,  0, 1,     "ovf_full");
      expect_at(s+17, K_LEVEL, 0, 16,    "ovf_level16");
      expect_at(s+17, K_LOSE,  0, 0,     "ovf_nolose");
      expect_at(s+18, K_LOSE,  0, 1,     "ovf_lose1");
      expect_at(s+21, K_LOSE,  0, 1,     "ovf_lose4");
      expect_at(s+22, K_LOSE,  0, 0,     "ovf_lose_end");
      expect_at(s+22, K_LOST,  0, 4,     "ovf_lost4");
      expect_at(s+22, K_FULL,  0, 1,     "ovf_full_hold");
      expect_at(s+22, K_LEVEL, 0, 16,    "ovf_level_hold");
      expect_at(s+276, K_LOST, 0, 254,   "sat_254");
      expect_at(s+277, K_LOST, 0, 255,   "sat_255");
      expect_at(s+326, K_LOSE, 0, 1,     "sat_lose_last");
      expect_at(s+327, K_LOSE, 0, 0,     "sat_lose_end");
      expect_at(s+327, K_LOST, 0, 255,   "sat_stays");
      expect_at(s+340, K_LANE, 0, 32'h101, "ovf_drain_l0");
      expect_at(s+341, K_LANE, 1, 32'h102, "ovf_drain_l1");
      for (int i = 0; i <= 330; i++) begin
         handshake    = (i % 2 == 0);
         write_signal = (i >= 1 && i <= 20) || (i >= 26 && i <= 325);
         data_in      = 32'h100 + 32'(i);
         tick();
      end
      handshake = 1'b0;
      write_signal = 1'b0;
      repeat (30) tick();

      // ---------------- reset in the fourth sync cycle ----------------
      s = cyc;
      expect_at(s+3, K_LANE, 0, SYNCW, "rsync_in_sync");
      expect_at(s+3, K_LEVEL, 0, 2,    "rsync_level2");
      expect_lanes(s+4, IDLE, "rsync");
      expect_at(s+4, K_LOST,  0, 0,    "rsync_lost");
      expect_at(s+4, K_LEVEL, 0, 0,    "rsync_level");
      expect_at(s+4, K_FULL,  0, 0,    "rsync_full");
      expect_at(s+4, K_LOSE,  0, 0,    "rsync_losing");
      expect_at(s+7, K_LEVEL, 0, 1,    "rsync_post_level");
      expect_at(s+8, K_LANE, 0, IDLE,  "rsync_post_l0");
      expect_at(s+8, K_LANE, 1, 32'hC5, "rsync_post_l1");
      handshake = 1'b1;
      tick();
      handshake = 1'b0;
      data_in = 32'hC0;
      write_signal = 1'b1;
      tick();
      data_in = 32'hC1;
      tick();
      write_signal = 1'b0;
      tick();
      RST_N = 1'b0;
      tick();
      tick();
      RST_N = 1'b1;
      data_in = 32'hC5;
      write_signal = 1'b1;
      tick();
      write_signal = 1'b0;
      repeat (5) tick();

      // ---------------- test mode ----------------
      s = cyc;
      expect_at(s+4, K_LEVEL, 0, 3,     "tm_level3");
      for (int l = 0; l < 4; l++) begin
         expect_at(s+6, K_LANE, l, 32'hA0 + 32'(l), $sformatf("tm_atuA_l%0d", l));
         expect_at(s+7, K_LANE, l, 32'hD0 + 32'(l), $sformatf("tm_atuD_l%0d", l));
      end
      expect_at(s+6, K_LEVEL, 0, 0,     "tm_level_clr");
      for (int c = 6; c <= 9; c++) expect_at(s+c, K_LOSE, 0, 0, $sformatf("tm_nolose%0d", c));
      expect_at(s+9,  K_LOST,  0, 0,    "tm_lost");
      expect_at(s+9,  K_LEVEL, 0, 0,    "tm_exit_level");
      expect_at(s+10, K_LEVEL, 0, 0,    "tm_run_level");
      expect_at(s+10, K_LANE, 0, IDLE,  "tm_run_l0");
      handshake = 1'b1;
      tick();
      handshake = 1'b0;
      data_in = 32'hB0;
      write_signal = 1'b1;
      tick();
      data_in = 32'hB1;
      tick();
      data_in = 32'hB2;
      tick();
      write_signal = 1'b0;
      test_mode = 1'b1;
      data_atu = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
      tick();
      data_in = 32'hEE;
      write_signal = 1'b1;
      tick();
      data_atu = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
      tick();
      tick();
      test_mode = 1'b0;
      tick();
      write_signal = 1'b0;
      repeat (4) tick();

      // ---------------- wrap up ----------------
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         checks++;
         errors++;
         $display("FAIL %s: never compared (due cycle %0d)", e.name, e.cyc);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
